// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan code set 2 decoder: resolves E0/F0/E1 prefixes, drops keyboard control
// bytes, and queues {break, extended, code} events in a small FIFO for the CPU side.
//
// state   | meaning
// IDLE    | no prefix pending
// E0      | extended prefix seen
// F0      | break prefix seen
// E0F0    | extended break prefix seen
// E1_SKIP | swallowing the rest of the 8-byte pause sequence
module ps2_scancode_decoder #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [7:0]               data_i,
  input  logic                     valid_i,
  output logic [9:0]               event_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_E1_SKIP
  } state_t;

  state_t      state, state_n;
  logic [2:0]  skip, skip_n;
  logic        push;
  logic [9:0]  push_data;
  logic        is_ctrl;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push_ok;

  always_comb begin
    is_ctrl = 1'b0;
    case (data_i)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default: is_ctrl = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= S_IDLE;
      skip  <= 3'd0;
    end else begin
      state <= state_n;
      skip  <= skip_n;
    end
  end

  always_comb begin
    state_n   = state;
    skip_n    = skip;
    push      = 1'b0;
    push_data = 10'd0;
    if (valid_i) begin
      if (state == S_E1_SKIP) begin
        // Every byte of the pause sequence counts, prefixes included.
        skip_n = skip - 3'd1;
        if (skip == 3'd1) begin
          push      = 1'b1;
          push_data = {1'b0, 1'b1, 8'h77};
          state_n   = S_IDLE;
        end
      end else if (is_ctrl) begin
        state_n = S_IDLE;
      end else if (data_i == byte_t'(8'hE1)) begin
        state_n = S_E1_SKIP;
        skip_n  = 3'd7;
      end else if (data_i == byte_t'(8'hE0)) begin
        state_n = S_E0;
      end else if (data_i == byte_t'(8'hF0)) begin
        state_n = (state == S_E0 || state == S_E0F0) ? S_E0F0 : S_F0;
      end else begin
        push      = 1'b1;
        push_data = {(state == S_F0 || state == S_E0F0),
                     (state == S_E0 || state == S_E0F0), data_i};
        state_n   = S_IDLE;
      end
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign pop     = valid_o && ready_i;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow_o <= 1'b1;
    end
  end

  assign valid_o = (count != '0);
  assign count_o = count;
  assign event_o = valid_o ? mem[rd_ptr] : 10'd0;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: prefix decoding, control bytes, pause
// sequence, FIFO full/overflow and reset behaviour against hand-computed events.
module tb_ps2_scancode_decoder;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic [9:0] event_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [3:0] count_o;
  logic       overflow_o;

  int errors = 0;
  int checks = 0;

  ps2_scancode_decoder #(.DEPTH(8)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .event_o    (event_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_i);
    data_i  = b;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [9:0] exp);
    chk({tag, "_valid"}, 16'(valid_o), 16'd1);
    chk(tag, 16'(event_o), 16'(exp));
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 16'(valid_o), 16'd0);
    chk("rst_count", 16'(count_o), 16'd0);
    chk("rst_ovf", 16'(overflow_o), 16'd0);
    chk("rst_event", 16'(event_o), 16'd0);

    // Idle consumer: event visible one cycle, then drained.
    ready_i = 1'b1;
    send(8'h76);
    chk("make_valid", 16'(valid_o), 16'd1);
    chk("make_event", 16'(event_o), 16'h076);
    chk("make_count", 16'(count_o), 16'd1);
    @(negedge clk_i);
    chk("make_drained", 16'(count_o), 16'd0);
    ready_i = 1'b0;

    // Underflow guard: ready while empty.
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("empty_pop_count", 16'(count_o), 16'd0);
    ready_i = 1'b0;

    send(8'hF0); send(8'h76);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("prefix_count", 16'(count_o), 16'd3);
    pop_chk("brk76", 10'h276);
    pop_chk("ext75", 10'h175);
    pop_chk("extbrk75", 10'h375);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    chk("pause_count", 16'(count_o), 16'd2);
    pop_chk("pause", 10'h177);
    pop_chk("after_pause", 10'h01C);

    send(8'hAA); send(8'hFA); send(8'hEE); send(8'hFE); send(8'h00); send(8'hFF);
    send(8'hF0); send(8'hAA); send(8'h1C);
    chk("ctrl_count", 16'(count_o), 16'd1);
    pop_chk("ctrl_cancel", 10'h01C);
    chk("ctrl_empty", 16'(count_o), 16'd0);

    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("full_count", 16'(count_o), 16'd8);
    chk("full_ovf", 16'(overflow_o), 16'd1);
    for (int i = 1; i <= 8; i++) pop_chk($sformatf("drain%0d", i), 10'(i));
    chk("drain_empty", 16'(count_o), 16'd0);
    chk("ovf_sticky", 16'(overflow_o), 16'd1);

    do_reset();
    chk("rst2_ovf", 16'(overflow_o), 16'd0);
    for (int i = 8'h11; i <= 8'h18; i++) send(8'(i));
    chk("full2_count", 16'(count_o), 16'd8);
    @(negedge clk_i);
    data_i  = 8'h19;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    ready_i = 1'b0;
    chk("pushpop_count", 16'(count_o), 16'd8);
    chk("pushpop_ovf", 16'(overflow_o), 16'd0);
    for (int i = 8'h12; i <= 8'h19; i++) pop_chk($sformatf("drain2_%0h", i), 10'(i));
    chk("drain2_empty", 16'(count_o), 16'd0);

    send(8'hE0);
    do_reset();
    chk("rst3_valid", 16'(valid_o), 16'd0);
    chk("rst3_count", 16'(count_o), 16'd0);
    chk("rst3_ovf", 16'(overflow_o), 16'd0);
    send(8'h1C);
    pop_chk("rst_clears_e0", 10'h01C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Consumes the byte stream produced by ps2_rx and decodes PS/2 scan code set 2 into key events. Each event carries the key code, a make/break flag and an extended (E0) flag. Prefix bytes (E0, F0, the E1 pause sequence) are resolved here, and keyboard control bytes are discarded. Decoded events are buffered in a small FIFO that the keyboard MMIO/CPU side drains through a valid/ready handshake.

Parameters:
DEPTH, 8, number of FIFO event entries; power of 2, minimum 2.

Ports:
clk_i  input  1  system clock
reset_i  input  1  synchronous, active-high reset
data_i  input  8 (byte_t)  received byte from ps2_rx.data_o
valid_i  input  1  single-cycle strobe qualifying data_i (from ps2_rx.valid_o); no backpressure upstream
event_o  output  10  head-of-FIFO event: bit9 break, bit8 extended, bits7:0 key code
valid_o  output  1  FIFO non-empty
ready_i  input  1  consumer accepts event_o; pop occurs on valid_o && ready_i
count_o  output  $clog2(DEPTH)+1  number of events in FIFO
overflow_o  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, reset_i high at clk edge): FSM to IDLE, skip counter 0, FIFO emptied.
- Reset values: valid_o=0, count_o=0, overflow_o=0, event_o=0.
- Reset mid-sequence discards any pending prefix state.
- Decoder FSM advances only on cycles with valid_i=1. States: IDLE, E0, F0, E0F0, E1_SKIP.
- Control bytes 00, AA, EE, FA, FE, FF in IDLE/E0/F0/E0F0: discarded, no event, state -> IDLE.
- Byte E1 in IDLE/E0/F0/E0F0: state -> E1_SKIP, skip counter = 7.
- Byte E0: from IDLE/E0/F0/E0F0 -> E0 (any pending break is cleared).
- Byte F0: IDLE -> F0; E0 -> E0F0; F0 stays F0; E0F0 stays E0F0.
- Any other byte b (code byte):
  - in IDLE push {0,0,b}; in E0 push {0,1,b}; in F0 push {1,0,b}; in E0F0 push {1,1,b}.
  - In every case state -> IDLE.
- E1_SKIP: every valid byte, including E0/F0/E1/control, decrements the counter. The byte that takes it from 1 to 0 pushes {0,1,8'h77} (Pause) and returns to IDLE. This gives exactly one event per 8-byte sequence E1 14 77 E1 F0 14 F0 77.
- Latency: code byte accepted at edge N (valid_i=1 in the cycle before) -> event written at edge N. valid_o/event_o reflect it in the cycle after edge N when the FIFO was empty, i.e. 1 cycle.
- FIFO: registered circular buffer with read/write pointers of width $clog2(DEPTH) that wrap modulo DEPTH. event_o is driven combinationally from the head entry and is held stable while valid_o=1 and ready_i=0.
- Pop: valid_o && ready_i removes the head. ready_i while empty has no effect; count does not underflow.
- Push and pop in the same cycle: both occur, count unchanged. This is also allowed when full: the push is accepted and there is no overflow.
- Push while full with no pop: event dropped, FIFO unchanged, overflow_o set to 1. overflow_o is cleared only by reset.
- count_o ranges 0..DEPTH.

Test Plan:
- Bytes 76 (idle consumer, ready_i=1): one event {break=0,ext=0,code=76}, i.e. event_o=10'h076, valid_o high for 1 cycle -> count returns to 0.
- Bytes F0 76, then E0 75, then E0 F0 75: events 10'h276, 10'h175, 10'h375 in order. No events for the prefix bytes.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C: exactly two events, 10'h177 then 10'h01C.
- Control bytes AA, FA, EE, FE, 00, FF interleaved, and F0 followed by AA then 1C: no events for the control bytes; the final 1C yields 10'h01C, confirming the break was cancelled.
- ready_i=0, send 9 make codes 01..09 with DEPTH=8: count_o=8, overflow_o=1, draining yields 01..08 only.
- Full FIFO with a simultaneous pop and push: count stays 8, overflow_o stays 0.
- E0 then reset_i pulse, then 1C: event 10'h01C (extended cleared). After reset valid_o=0, count_o=0, overflow_o=0.
